// File: rtl/jk_load_sequencer.sv
// Sequences a bank of JK flip-flops to a requested value.
// It reads the bank back, retries on a mismatch, and flags an error when the retries run out.
module jk_load_sequencer #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [1:0]       load_op,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] ff_q,
  output logic [WIDTH-1:0] ff_j,
  output logic [WIDTH-1:0] ff_k,
  output logic             ff_reset,
  output logic             ff_set,
  output logic             done,
  output logic             error
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SETALL,
    WRITE,
    TOG,
    VERIFY,
    DONE,
    ERR
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] target_d;
  logic [RW-1:0]    retry_q;
  logic             error_q;
  logic             accept;
  logic             retry_inc;
  logic             verify_ok;
  logic             at_max;

  assign accept    = load_valid && (state_q == IDLE);
  assign verify_ok = (ff_q == target_q);
  assign at_max    = (retry_q == RW'(MAX_RETRY));

  always_comb begin
    target_d = ~ff_q;
    case (load_op)
      OP_LOAD:   target_d = load_data;
      OP_CLEAR:  target_d = '0;
      OP_PRESET: target_d = '1;
      default:   target_d = ~ff_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          case (load_op)
            OP_LOAD,
            OP_CLEAR:  state_d = CLR;
            OP_PRESET: state_d = SETALL;
            default:   state_d = TOG;
          endcase
        end
      end
      CLR: begin
        if (op_q == OP_CLEAR) state_d = VERIFY;
        else                  state_d = WRITE;
      end
      SETALL: state_d = VERIFY;
      WRITE:  state_d = VERIFY;
      TOG:    state_d = VERIFY;
      VERIFY: begin
        if (verify_ok) begin
          state_d = DONE;
        end else if (at_max) begin
          state_d = ERR;
        end else begin
          retry_inc = 1'b1;
          // A failed toggle is retried as a plain load of its target
          if (op_q == OP_PRESET) state_d = SETALL;
          else                   state_d = CLR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_LOAD;
      target_q <= '0;
      retry_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= load_op;
        target_q <= target_d;
        retry_q  <= '0;
        error_q  <= 1'b0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
      if (state_d == ERR) error_q <= 1'b1;
    end
  end

  always_comb begin
    load_ready = (state_q == IDLE);
    ff_reset   = (state_q == CLR);
    ff_set     = (state_q == SETALL);
    done       = (state_q == DONE);
    error      = error_q;
    ff_j       = '0;
    ff_k       = '0;
    unique case (1'b1)
      (state_q == WRITE): begin
        ff_j = target_q;
        ff_k = ~target_q;
      end
      (state_q == TOG): begin
        ff_j = '1;
        ff_k = '1;
      end
      default: begin
        ff_j = '0;
        ff_k = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_load_sequencer.sv
// Testbench for jk_load_sequencer, driving an ideal JK bank model that can hold bits stuck at 0.
// A queue holds the expected outcome of each request and is checked when done or error is seen.
module tb_jk_load_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [1:0] load_op = 2'b00;
  logic [3:0] load_data = 4'h0;
  logic [3:0] ff_q;
  logic [3:0] ff_j;
  logic [3:0] ff_k;
  logic       ff_reset;
  logic       ff_set;
  logic       done;
  logic       error;

  logic [3:0] bank = 4'h0;
  logic [3:0] stuck = 4'h0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_acc = 0;
  int rst_pulses = 0;
  int set_pulses = 0;
  int tog_cycles = 0;
  int viol = 0;
  logic err_q = 1'b0;

  typedef struct {
    logic [3:0] q;
    int         lat;
    bit         err;
  } exp_t;

  exp_t sb[$];

  jk_load_sequencer #(.WIDTH(4), .MAX_RETRY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_op    (load_op),
    .load_data  (load_data),
    .ff_q       (ff_q),
    .ff_j       (ff_j),
    .ff_k       (ff_k),
    .ff_reset   (ff_reset),
    .ff_set     (ff_set),
    .done       (done),
    .error      (error)
  );

  assign ff_q = bank;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ideal bank: clocked on the falling edge, reset/set dominant
  always @(negedge clk) begin
    logic [3:0] nb;
    if (ff_reset)    nb = 4'h0;
    else if (ff_set) nb = 4'hF;
    else             nb = (ff_j & ~bank) | (~ff_k & bank);
    bank <= nb & ~stuck;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && load_valid && load_ready) begin
      acc_cyc <= cyc;
      n_acc   <= n_acc + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic ev_err;
    ev_err = error && !err_q;
    err_q <= error;
    if (ff_reset) rst_pulses <= rst_pulses + 1;
    if (ff_set)   set_pulses <= set_pulses + 1;
    if (ff_j == 4'hF && ff_k == 4'hF) tog_cycles <= tog_cycles + 1;
    if ((ff_reset && ff_set) ||
        ((ff_j & ff_k) != 4'h0 && !(ff_j == 4'hF && ff_k == 4'hF)))
      viol <= viol + 1;
    if (!reset && (done || ev_err)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("kind_err", {31'b0, ev_err}, {31'b0, e.err});
        check("latency", cyc - acc_cyc, e.lat);
        if (!e.err) check("bank_q", {28'b0, bank}, {28'b0, e.q});
      end
    end
  end

  // Caller sits just after a rising edge; returns just after the accepting edge
  task automatic req(input logic [1:0] op, input logic [3:0] data,
                     input bit push, input bit err, input int lat);
    exp_t it;
    int n = 0;
    while (!load_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!load_ready) check("ready_timeout", 0, 1);
    load_op    = op;
    load_data  = data;
    load_valid = 1'b1;
    if (push) begin
      it.err = err;
      it.lat = lat;
      case (op)
        2'b00:   it.q = data;
        2'b01:   it.q = 4'h0;
        2'b10:   it.q = 4'hF;
        default: it.q = ~bank;
      endcase
      sb.push_back(it);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = 4'h0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic exp_t mk(input logic [3:0] q, input int lat);
    exp_t it;
    it.q   = q;
    it.lat = lat;
    it.err = 1'b0;
    return it;
  endfunction

  initial begin
    int rp;
    int sp;
    int tc;
    int na;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, load_ready}, 1);
    check("rst_done", {31'b0, done}, 0);
    check("rst_error", {31'b0, error}, 0);
    check("rst_drv", {24'b0, ff_j, ff_k}, 0);
    check("rst_rs", {30'b0, ff_reset, ff_set}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'b0, load_ready}, 1);

    // LOAD 0x9 with drive sequence
    req(2'b00, 4'h9, 1, 0, 4);
    @(negedge clk);
    check("load_ffreset_c1", {31'b0, ff_reset}, 1);
    @(negedge clk);
    check("load_jk_c2", {24'b0, ff_j, ff_k}, {24'b0, 4'h9, 4'h6});
    @(posedge clk); #1;
    drain();

    // TOGGLE from 0101
    req(2'b00, 4'h5, 1, 0, 4);
    drain();
    req(2'b11, 4'h0, 1, 0, 3);
    @(negedge clk);
    check("tog_jk_c1", {24'b0, ff_j, ff_k}, {24'b0, 8'hFF});
    @(posedge clk); #1;
    drain();

    // PRESET then CLEAR back to back
    rp = rst_pulses;
    sp = set_pulses;
    req(2'b10, 4'h3, 1, 0, 3);
    req(2'b01, 4'hC, 1, 0, 3);
    drain();
    check("set_pulses", set_pulses - sp, 1);
    check("rst_pulses", rst_pulses - rp, 1);

    // A few random loads
    for (int i = 0; i < 4; i++) begin
      req(2'b00, 4'($urandom_range(0, 15)), 1, 0, 4);
      drain();
    end

    // load_valid held through busy period, data changing
    na = n_acc;
    load_op    = 2'b00;
    load_data  = 4'h6;
    load_valid = 1'b1;
    sb.push_back(mk(4'h6, 4));
    @(posedge clk); #1;
    load_data = 4'h5;
    @(posedge clk); #1;
    load_data = 4'hA;
    sb.push_back(mk(4'hA, 4));
    n = 0;
    while (n_acc - na < 2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    load_valid = 1'b0;
    check("hold_accepts", n_acc - na, 2);
    drain();
    check("hold_no_extra", n_acc - na, 2);

    // Stuck bit 2: LOAD 0xF exhausts retries
    stuck = 4'h4;
    req(2'b00, 4'hF, 1, 1, 10);
    drain();
    check("err_set", {31'b0, error}, 1);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", {31'b0, error}, 1);
    check("err_ready", {31'b0, load_ready}, 1);
    req(2'b00, 4'h3, 1, 0, 4);
    @(negedge clk);
    check("err_cleared", {31'b0, error}, 0);
    @(posedge clk); #1;
    drain();

    // TOGGLE failing: retries must go through load path, one TOG only
    tc = tog_cycles;
    req(2'b11, 4'h0, 1, 1, 9);
    drain();
    check("tog_once", tog_cycles - tc, 1);
    req(2'b00, 4'h0, 1, 0, 4);
    drain();
    stuck = 4'h0;

    // Reset during WRITE
    req(2'b00, 4'h6, 0, 0, 0);
    @(posedge clk); #1;
    rp = rst_pulses;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rw_ready", {31'b0, load_ready}, 1);
    check("rw_drv", {24'b0, ff_j, ff_k}, 0);
    check("rw_rs", {30'b0, ff_reset, ff_set}, 0);
    @(negedge clk);
    check("rw_no_ffreset", rst_pulses - rp, 0);
    @(posedge clk); #1;

    // Reset overrides an accept
    reset      = 1'b1;
    load_valid = 1'b1;
    load_op    = 2'b10;
    @(posedge clk); #1;
    reset      = 1'b0;
    load_valid = 1'b0;
    check("rst_over_acc", {31'b0, load_ready}, 1);
    @(negedge clk);
    check("rst_over_set", {31'b0, ff_set}, 0);
    @(posedge clk); #1;
    req(2'b01, 4'h0, 1, 0, 3);
    drain();

    check("excl_viol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_load_sequencer.md
JK_LOAD_SEQUENCER -- requirements
Module: jk_load_sequencer

Interface
REQ-001 Parameter WIDTH, default 4: number of JK flip-flops in the driven bank.
REQ-002 Parameter MAX_RETRY, default 2: verify-failure retries before error.
REQ-003 clk  input  1  system clock; all block state SHALL update on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 load_valid  input  1  request strobe.
REQ-006 load_ready  output  1  block idle and able to accept a request.
REQ-007 load_op  input  2  00=LOAD, 01=CLEAR, 10=PRESET, 11=TOGGLE.
REQ-008 load_data  input  WIDTH  target value for LOAD; ignored for other ops.
REQ-009 ff_q  input  WIDTH  q outputs of the bank; bank samples on falling edge of clk.
REQ-010 ff_j  output  WIDTH  per-bit J drive.
REQ-011 ff_k  output  WIDTH  per-bit K drive.
REQ-012 ff_reset  output  1  common reset drive to bank.
REQ-013 ff_set  output  1  common set drive to bank.
REQ-014 done  output  1  one-cycle pulse on verified completion.
REQ-015 error  output  1  sticky failure flag.

Function
REQ-016 States SHALL be IDLE, CLR, SETALL, WRITE, TOG, VERIFY, DONE, ERR; all outputs SHALL be decoded from registered state only (Moore).
REQ-017 IDLE: load_ready=1; ff_j=ff_k=0; ff_reset=ff_set=0; done=0.
REQ-018 Accept occurs on a rising edge with load_valid=1 and load_ready=1; load_op, load_data captured; retry count cleared; error cleared.
REQ-019 load_valid while load_ready=0 SHALL be ignored; inputs need not stay stable after accept.
REQ-020 LOAD path: CLR (ff_reset=1) -> WRITE (ff_j=target, ff_k=~target) -> VERIFY; target=load_data.
REQ-021 CLEAR path: CLR -> VERIFY; target=0.
REQ-022 PRESET path: SETALL (ff_set=1) -> VERIFY; target=all ones.
REQ-023 TOGGLE path: target=~ff_q captured at accept; TOG (ff_j=ff_k=all ones) -> VERIFY.
REQ-024 Each of CLR, SETALL, WRITE, TOG SHALL last exactly one cycle.
REQ-025 VERIFY: all drives 0; ff_q==target -> DONE; mismatch with retry<MAX_RETRY -> retry+1, re-enter path; mismatch with retry==MAX_RETRY -> ERR.
REQ-026 TOGGLE retry SHALL use LOAD path (CLR, WRITE) with the captured target, never TOG.
REQ-027 DONE: done=1 one cycle, then IDLE; load_ready=0 in DONE.
REQ-028 ERR: one cycle, then IDLE; error=1 from entering ERR until next accept or reset.
REQ-029 ff_reset and ff_set SHALL never be high together; ff_j&ff_k nonzero only in TOG.
REQ-030 Latency accept-to-done, no retries: LOAD 4 cycles, CLEAR/PRESET/TOGGLE 3 cycles.
REQ-031 Worst case accept-to-ERR: LOAD (MAX_RETRY+1)*3+1 cycles.

Reset
REQ-032 reset=1 on a rising edge SHALL force IDLE, retry=0, error=0, done=0, all drives 0, regardless of state, overriding accept.
REQ-033 reset SHALL NOT assert ff_reset; bank contents untouched by block reset.
REQ-034 First cycle after reset deasserts: load_ready=1.

Verification
REQ-035 WIDTH=4, bank model ideal; LOAD 0x9 -> ff_reset cycle 1, j=1001 k=0110 cycle 2, done at cycle 4, ff_q=1001.
REQ-036 ff_q=0101, TOGGLE -> ff_j=ff_k=1111 cycle 1, done cycle 3, ff_q=1010.
REQ-037 Bank bit 2 stuck at 0, LOAD 0xF -> three CLR/WRITE/VERIFY passes, ERR at cycle 10, error=1, done never high; next accept clears error.
REQ-038 reset asserted during WRITE -> next cycle IDLE, drives 0, load_ready=1, ff_reset not pulsed.
REQ-039 load_valid held high through busy period with changing load_data -> only first value loaded; second accepted in IDLE after DONE.
REQ-040 PRESET then CLEAR back-to-back -> ff_set and ff_reset each one cycle, never overlapping, ff_q 1111 then 0000.
